// File: rtl/seg7_scan_if.sv
// Display-side bundle of the 7-segment scan driver: async scan clock, digit data in, display pins out.
interface seg7_scan_if;
  logic        c1khz;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        stall;

  modport master (
    output c1khz, digits, blank, dp,
    input  an, seg, dp_n, stall
  );

  modport slave (
    input  c1khz, digits, blank, dp,
    output an, seg, dp_n, stall
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver clocked by an externally divided 1 kHz
// scan wave, with a watchdog that blanks the display when the scan wave dies.
module seg7_scan_driver #(
  parameter int unsigned STALL_CYCLES = 200000,
  parameter int unsigned CNT_W        = 18
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned SEG_W = 7;
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_CYCLES);

  logic             s1, s2, s3;
  logic             tick_c;
  logic [IDX_W-1:0] idx, idx_next;
  logic [CNT_W-1:0] wd_cnt, wd_cnt_next;
  logic             stall_r, stall_next;
  logic [AN_W-1:0]  an_r, an_next;
  logic [SEG_W-1:0] seg_r, seg_next;
  logic             dp_n_r, dp_n_next;
  logic [DIG_W-1:0] digit_c;
  logic [SEG_W-1:0] glyph_c;

  // Three-flop chain: two for metastability, the third for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.c1khz;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick_c = s2 & ~s3;

  // Scan index and watchdog next state; a tick always beats the stall limit.
  always_comb begin
    idx_next    = idx;
    wd_cnt_next = wd_cnt;
    stall_next  = stall_r;
    if (tick_c) begin
      idx_next    = IDX_W'(idx + 1'b1);
      wd_cnt_next = '0;
      stall_next  = 1'b0;
    end else begin
      if (wd_cnt != STALL_LIM) begin
        wd_cnt_next = CNT_W'(wd_cnt + 1'b1);
      end
      if (wd_cnt_next == STALL_LIM) begin
        stall_next = 1'b1;
      end
    end
  end

  // Hex to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    digit_c = bus.digits[{idx_next, 2'b00} +: DIG_W];
    glyph_c = 7'b1111111;
    case (digit_c)
      4'h0:    glyph_c = 7'b1000000;
      4'h1:    glyph_c = 7'b1111001;
      4'h2:    glyph_c = 7'b0100100;
      4'h3:    glyph_c = 7'b0110000;
      4'h4:    glyph_c = 7'b0011001;
      4'h5:    glyph_c = 7'b0010010;
      4'h6:    glyph_c = 7'b0000010;
      4'h7:    glyph_c = 7'b1111000;
      4'h8:    glyph_c = 7'b0000000;
      4'h9:    glyph_c = 7'b0010000;
      4'hA:    glyph_c = 7'b0001000;
      4'hB:    glyph_c = 7'b0000011;
      4'hC:    glyph_c = 7'b1000110;
      4'hD:    glyph_c = 7'b0100001;
      4'hE:    glyph_c = 7'b0000110;
      4'hF:    glyph_c = 7'b0001110;
      default: glyph_c = 7'b1111111;
    endcase
  end

  // Outputs follow idx_next so anode and segments switch on the same edge.
  always_comb begin
    an_next   = '1;
    seg_next  = '1;
    dp_n_next = 1'b1;
    if (!stall_next && !bus.blank[idx_next]) begin
      an_next   = ~(AN_W'(1) << idx_next);
      seg_next  = glyph_c;
      dp_n_next = ~bus.dp[idx_next];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      wd_cnt  <= '0;
      stall_r <= 1'b0;
      an_r    <= '1;
      seg_r   <= '1;
      dp_n_r  <= 1'b1;
    end else begin
      idx     <= idx_next;
      wd_cnt  <= wd_cnt_next;
      stall_r <= stall_next;
      an_r    <= an_next;
      seg_r   <= seg_next;
      dp_n_r  <= dp_n_next;
    end
  end

  assign bus.an    = an_r;
  assign bus.seg   = seg_r;
  assign bus.dp_n  = dp_n_r;
  assign bus.stall = stall_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver with a shortened watchdog and scan period.
module tb_seg7_scan_driver;

  localparam int unsigned STALL = 200;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned HALF  = 50;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       stall;
  } disp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg7_scan_if bus ();

  seg7_scan_driver #(
    .STALL_CYCLES (STALL),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  disp_t      exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [6:0] glyph [16];
  logic [3:0] scan_val [4];

  function automatic disp_t lit(input logic [1:0] pos, input logic [3:0] val, input logic dp_on);
    disp_t e;
    e.an      = 4'b1111;
    e.an[pos] = 1'b0;
    e.seg     = glyph[val];
    e.dp_n    = ~dp_on;
    e.stall   = 1'b0;
    return e;
  endfunction

  function automatic disp_t dark(input logic st);
    disp_t e;
    e.an    = 4'b1111;
    e.seg   = 7'b1111111;
    e.dp_n  = 1'b1;
    e.stall = st;
    return e;
  endfunction

  task automatic check(input string tag);
    disp_t obs;
    disp_t e;
    obs.an    = bus.an;
    obs.seg   = bus.seg;
    obs.dp_n  = bus.dp_n;
    obs.stall = bus.stall;
    vectors++;
    assert (exp_q.size() != 0) else begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed an=%b seg=%b", tag, obs.an, obs.seg);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed an=%b seg=%b dp_n=%b stall=%b, expected an=%b seg=%b dp_n=%b stall=%b",
               tag, obs.an, obs.seg, obs.dp_n, obs.stall, e.an, e.seg, e.dp_n, e.stall);
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Raise c1khz between edges; display must hold for two edges and change on the third.
  task automatic rise(input string tag, input disp_t before_e, input disp_t after_e);
    @(negedge clk);
    bus.c1khz = 1'b1;
    exp_q.push_back(before_e);
    exp_q.push_back(after_e);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check({tag, "/pre"});
    @(posedge clk);
    @(negedge clk);
    check({tag, "/post"});
  endtask

  // Finish the high half, drop c1khz, and confirm the falling edge does nothing.
  task automatic rest(input disp_t hold_e);
    idle(HALF - 3);
    bus.c1khz = 1'b0;
    exp_q.push_back(hold_e);
    idle(5);
    check("fall_no_tick");
    idle(HALF - 5);
  endtask

  // One-cycle-wide pulse of c1khz, sampled by exactly one clk edge.
  task automatic glitch(input string tag, input disp_t before_e, input disp_t after_e);
    @(negedge clk);
    bus.c1khz = 1'b1;
    exp_q.push_back(before_e);
    exp_q.push_back(after_e);
    exp_q.push_back(after_e);
    @(negedge clk);
    bus.c1khz = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "/pre"});
    @(posedge clk);
    @(negedge clk);
    check({tag, "/post"});
    idle(6);
    check({tag, "/single"});
  endtask

  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    scan_val = '{4'h4, 4'h3, 4'h2, 4'h1};

    bus.c1khz  = 1'b0;
    bus.digits = 16'h1234;
    bus.blank  = 4'b0000;
    bus.dp     = 4'b0000;
    rst        = 1'b0;
    idle(3);
    exp_q.push_back(dark(1'b0));
    check("reset");

    rst = 1'b1;
    exp_q.push_back(lit(2'd0, 4'h4, 1'b0));
    @(posedge clk);
    @(negedge clk);
    check("first_edge");

    // Full scan of 1234 and wrap back to digit 0
    for (int i = 1; i <= 4; i++) begin
      rise("scan", lit(2'(i - 1), scan_val[2'(i - 1)], 1'b0), lit(2'(i), scan_val[2'(i)], 1'b0));
      rest(lit(2'(i), scan_val[2'(i)], 1'b0));
    end

    // New data, blank on digit 2, dp on digit 0
    @(negedge clk);
    bus.digits = 16'hF0A8;
    bus.blank  = 4'b0100;
    bus.dp     = 4'b0001;
    exp_q.push_back(lit(2'd0, 4'h8, 1'b1));
    @(posedge clk);
    @(negedge clk);
    check("digit_update");
    rise("f0a8_1", lit(2'd0, 4'h8, 1'b1), lit(2'd1, 4'hA, 1'b0));
    rest(lit(2'd1, 4'hA, 1'b0));
    rise("f0a8_2", lit(2'd1, 4'hA, 1'b0), dark(1'b0));
    rest(dark(1'b0));
    rise("f0a8_3", dark(1'b0), lit(2'd3, 4'hF, 1'b0));
    rest(lit(2'd3, 4'hF, 1'b0));

    // Watchdog: stall exactly STALL edges after the last tick edge
    rise("pre_stall", lit(2'd3, 4'hF, 1'b0), lit(2'd0, 4'h8, 1'b1));
    idle(HALF);
    bus.c1khz = 1'b0;
    idle(STALL - 1 - HALF);
    exp_q.push_back(lit(2'd0, 4'h8, 1'b1));
    check("stall_edge_minus1");
    idle(1);
    exp_q.push_back(dark(1'b1));
    check("stall_on");
    idle(20);
    exp_q.push_back(dark(1'b1));
    check("stall_hold");
    rise("stall_clear", dark(1'b1), lit(2'd1, 4'hA, 1'b0));
    rest(lit(2'd1, 4'hA, 1'b0));

    // Async reset while digit 2 is lit
    @(negedge clk);
    bus.blank = 4'b0000;
    exp_q.push_back(lit(2'd1, 4'hA, 1'b0));
    idle(1);
    check("unblank");
    rise("to_idx2", lit(2'd1, 4'hA, 1'b0), lit(2'd2, 4'h0, 1'b0));
    idle(5);
    bus.c1khz = 1'b0;
    idle(3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    exp_q.push_back(dark(1'b0));
    check("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(dark(1'b0));
    check("reset_hold");
    rst = 1'b1;
    exp_q.push_back(lit(2'd0, 4'h8, 1'b1));
    @(posedge clk);
    @(negedge clk);
    check("restart");

    // Narrow pulses still give exactly one advance each
    glitch("glitch1", lit(2'd0, 4'h8, 1'b1), lit(2'd1, 4'hA, 1'b0));
    glitch("glitch2", lit(2'd1, 4'hA, 1'b0), lit(2'd2, 4'h0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
